// File: rtl/reset_seq.sv
// reset_seq: reset sequencer that merges system, external-pin and software
// reset requests. It holds every channel reset asserted for a minimum time,
// then releases the NCH active-low channel resets in ascending order with a
// programmable gap between releases. It also reports the cause of the last
// reset.
// Optional watchdog: define RESET_SEQ_WDT_EN to add WDT_CYC, wdt_kick and
// wdt_fired.
module reset_seq #(
  parameter int NCH         = 4,
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYC    = 16,
  parameter int GAP_CYC     = 4,
  parameter int FILTER_CYC  = 3
`ifdef RESET_SEQ_WDT_EN
  , parameter int WDT_CYC   = 1024
`endif
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           ext_rst_req_n,
  input  logic           sw_rst_req,
`ifdef RESET_SEQ_WDT_EN
  input  logic           wdt_kick,
  output logic           wdt_fired,
`endif
  output logic [NCH-1:0] ch_rst_n,
  output logic           done,
  output logic [1:0]     rst_cause
);

  localparam int MAXHG = (HOLD_CYC > GAP_CYC) ? HOLD_CYC : GAP_CYC;
  localparam int MAXC  = (MAXHG > FILTER_CYC) ? MAXHG : FILTER_CYC;
  localparam int CW    = $clog2(MAXC + 1);
  localparam int IW    = (NCH > 1) ? $clog2(NCH) : 1;

  localparam logic [CW-1:0] ONE       = CW'(1);
  localparam logic [CW-1:0] FLT_MAX   = CW'(FILTER_CYC);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYC - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NCH - 1);

  localparam logic [1:0] S_ASSERT  = 2'd0;
  localparam logic [1:0] S_RELEASE = 2'd1;
  localparam logic [1:0] S_RUN     = 2'd2;

  localparam logic [1:0] CAUSE_EXT = 2'd1;
  localparam logic [1:0] CAUSE_SW  = 2'd2;
`ifdef RESET_SEQ_WDT_EN
  localparam logic [1:0] CAUSE_WDT = 2'd3;
`endif

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          flt_q;
  logic                   ext_req;

  logic [1:0]     state_q, state_d;
  logic [CW-1:0]  hold_q, hold_d;
  logic [CW-1:0]  gap_q, gap_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic [NCH-1:0] ch_q, ch_d;
  logic           done_q, done_d;
  logic [1:0]     cause_q, cause_d;

  logic           req_any;
  logic [1:0]     req_cause;

  // External pin: synchronise, then accept only after FILTER_CYC consecutive low samples
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '1;
      flt_q  <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], ext_rst_req_n};
      if (sync_q[SYNC_STAGES-1]) begin
        flt_q <= '0;
      end else if (flt_q != FLT_MAX) begin
        flt_q <= flt_q + ONE;
      end
    end
  end

  assign ext_req = (flt_q == FLT_MAX);

`ifdef RESET_SEQ_WDT_EN
  localparam int WW = $clog2(WDT_CYC + 1);
  localparam logic [WW-1:0] WDT_LAST = WW'(WDT_CYC - 1);

  logic [WW-1:0] wdt_q;
  logic          wdt_fired_q;
  logic          wdt_req;

  // The request fires on the WDT_CYC-th unkicked edge spent in RUN
  assign wdt_req = (state_q == S_RUN) && !wdt_kick && (wdt_q == WDT_LAST);

  // Watchdog counter runs only in RUN; fired flag is sticky until rst_n
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wdt_q       <= '0;
      wdt_fired_q <= 1'b0;
    end else begin
      if ((state_q != S_RUN) || wdt_kick || wdt_req) begin
        wdt_q <= '0;
      end else begin
        wdt_q <= wdt_q + WW'(1);
      end
      if (wdt_req) begin
        wdt_fired_q <= 1'b1;
      end
    end
  end

  assign wdt_fired = wdt_fired_q;
`endif

  // Merge request sources; the highest-priority active source names the cause
  always_comb begin
    req_cause = CAUSE_SW;
`ifdef RESET_SEQ_WDT_EN
    req_any = ext_req | wdt_req | sw_rst_req;
    if (ext_req) begin
      req_cause = CAUSE_EXT;
    end else if (wdt_req) begin
      req_cause = CAUSE_WDT;
    end
`else
    req_any = ext_req | sw_rst_req;
    if (ext_req) begin
      req_cause = CAUSE_EXT;
    end
`endif
  end

  // Sequencer next state: any request restarts the hold; otherwise hold, then release in order
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    gap_d   = gap_q;
    idx_d   = idx_q;
    ch_d    = ch_q;
    done_d  = done_q;
    cause_d = cause_q;
    if (req_any) begin
      state_d = S_ASSERT;
      hold_d  = '0;
      gap_d   = '0;
      idx_d   = '0;
      ch_d    = '0;
      done_d  = 1'b0;
      cause_d = req_cause;
    end else begin
      case (state_q)
        S_ASSERT: begin
          if (hold_q == HOLD_LAST) begin
            hold_d  = '0;
            ch_d[0] = 1'b1;
            idx_d   = IW'(1);
            if (NCH == 1) begin
              state_d = S_RUN;
              done_d  = 1'b1;
            end else begin
              state_d = S_RELEASE;
            end
          end else begin
            hold_d = hold_q + ONE;
          end
        end
        S_RELEASE: begin
          if (gap_q == GAP_LAST) begin
            gap_d       = '0;
            ch_d[idx_q] = 1'b1;
            if (idx_q == IDX_LAST) begin
              state_d = S_RUN;
              done_d  = 1'b1;
            end else begin
              idx_d = idx_q + IW'(1);
            end
          end else begin
            gap_d = gap_q + ONE;
          end
        end
        S_RUN: begin
          state_d = S_RUN;
        end
        default: begin
          state_d = S_ASSERT;
          ch_d    = '0;
          done_d  = 1'b0;
        end
      endcase
    end
  end

  // Sequencer state registers; rst_n is the top-priority reset source
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_ASSERT;
      hold_q  <= '0;
      gap_q   <= '0;
      idx_q   <= '0;
      ch_q    <= '0;
      done_q  <= 1'b0;
      cause_q <= 2'd0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      gap_q   <= gap_d;
      idx_q   <= idx_d;
      ch_q    <= ch_d;
      done_q  <= done_d;
      cause_q <= cause_d;
    end
  end

  assign ch_rst_n  = ch_q;
  assign done      = done_q;
  assign rst_cause = cause_q;

endmodule

// File: tb/tb_reset_seq.sv
// tb_reset_seq: scoreboard bench for reset_seq. Stimulus pushes the expected
// output changes and timed snapshots into queues. The monitor compares them
// against the DUT on every clock edge. A second instance (NCH=1, GAP_CYC=1)
// covers the single-channel build.
module tb_reset_seq;

  typedef struct {
    int         at;
    logic [3:0] ch;
    logic       dn;
    logic [1:0] cs;
    logic       d1_chk;
    logic       d1_ch;
    logic       d1_dn;
    logic       wf;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ext_rst_req_n = 1'b1;
  logic       sw_rst_req = 1'b0;
  logic       wdt_kick = 1'b1;
  logic [3:0] ch_rst_n;
  logic       done;
  logic [1:0] rst_cause;
  logic       d1_ch;
  logic       d1_dn;
  logic [1:0] d1_cause;
`ifdef RESET_SEQ_WDT_EN
  logic       wdt_fired;
  logic       d1_wf;
`endif

  exp_t evq[$];
  exp_t snapq[$];
  exp_t e;
  exp_t s;
  int   cyc = 0;
  int   nvec = 0;
  int   nerr = 0;
  bit   mon_en = 1'b0;
  bit   fin = 1'b0;
  bit   bad;
  logic [4:0] prev = 5'b0;
  logic [4:0] cur;

  always #5 clk = ~clk;

  reset_seq #(
    .NCH(4), .SYNC_STAGES(2), .HOLD_CYC(16), .GAP_CYC(4), .FILTER_CYC(3)
`ifdef RESET_SEQ_WDT_EN
    , .WDT_CYC(8)
`endif
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .ext_rst_req_n(ext_rst_req_n),
    .sw_rst_req(sw_rst_req),
`ifdef RESET_SEQ_WDT_EN
    .wdt_kick(wdt_kick),
    .wdt_fired(wdt_fired),
`endif
    .ch_rst_n(ch_rst_n),
    .done(done),
    .rst_cause(rst_cause)
  );

  reset_seq #(
    .NCH(1), .SYNC_STAGES(2), .HOLD_CYC(16), .GAP_CYC(1), .FILTER_CYC(3)
  ) dut1 (
    .clk(clk),
    .rst_n(rst_n),
    .ext_rst_req_n(1'b1),
    .sw_rst_req(1'b0),
`ifdef RESET_SEQ_WDT_EN
    .wdt_kick(wdt_kick),
    .wdt_fired(d1_wf),
`endif
    .ch_rst_n(d1_ch),
    .done(d1_dn),
    .rst_cause(d1_cause)
  );

  function automatic void ev(int at, logic [3:0] ch, logic dn, logic [1:0] cs);
    exp_t x;
    x.at = at; x.ch = ch; x.dn = dn; x.cs = cs;
    x.d1_chk = 1'b0; x.d1_ch = 1'b0; x.d1_dn = 1'b0; x.wf = 1'b0;
    evq.push_back(x);
  endfunction

  function automatic void snap(int at, logic [3:0] ch, logic dn, logic [1:0] cs,
                               logic d1_chk, logic d1c, logic d1d, logic wf);
    exp_t x;
    x.at = at; x.ch = ch; x.dn = dn; x.cs = cs;
    x.d1_chk = d1_chk; x.d1_ch = d1c; x.d1_dn = d1d; x.wf = wf;
    snapq.push_back(x);
  endfunction

  task automatic wait_to(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  // Monitor: counts edges, checks every output change and every timed snapshot
  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      cur = {ch_rst_n, done};
      if (mon_en && cur != prev) begin
        nvec++;
        if (evq.size() == 0) begin
          nerr++;
          $display("FAIL unexpected_change edge=%0d ch=%b done=%b cause=%0d, required no change",
                   cyc, ch_rst_n, done, rst_cause);
        end else begin
          e = evq.pop_front();
          if (e.at != cyc || e.ch != ch_rst_n || e.dn != done || e.cs != rst_cause) begin
            nerr++;
            $display("FAIL event edge=%0d ch=%b done=%b cause=%0d, required edge=%0d ch=%b done=%b cause=%0d",
                     cyc, ch_rst_n, done, rst_cause, e.at, e.ch, e.dn, e.cs);
          end
        end
      end
      prev = cur;
      while (snapq.size() > 0 && snapq[0].at <= cyc) begin
        s = snapq.pop_front();
        nvec++;
        bad = (s.at != cyc) || (ch_rst_n != s.ch) || (done != s.dn) || (rst_cause != s.cs);
        if (s.d1_chk && (d1_ch != s.d1_ch || d1_dn != s.d1_dn)) bad = 1'b1;
`ifdef RESET_SEQ_WDT_EN
        if (wdt_fired != s.wf) bad = 1'b1;
`endif
        if (bad) begin
          nerr++;
          $display("FAIL snapshot edge=%0d (req %0d) ch=%b done=%b cause=%0d d1=%b/%b, required ch=%b done=%b cause=%0d d1=%b/%b wf=%b",
                   cyc, s.at, ch_rst_n, done, rst_cause, d1_ch, d1_dn,
                   s.ch, s.dn, s.cs, s.d1_ch, s.d1_dn, s.wf);
        end
      end
      if (fin) begin
        nvec++;
        if (evq.size() != 0) begin
          nerr++;
          $display("FAIL missing_events pending=%0d, required 0 (next at edge %0d)", evq.size(), evq[0].at);
        end
        nvec++;
        if (snapq.size() != 0) begin
          nerr++;
          $display("FAIL missing_snapshots pending=%0d, required 0", snapq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
      end
    end
  end

  // Stimulus: directed scenarios with hand-computed edge numbers
  initial begin
    int b;
    // Reset state and power-up sequence
    snap(3, 4'b0000, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    wait_to(5);
    b = cyc;
    rst_n = 1'b1;
    mon_en = 1'b1;
    snap(b + 15, 4'b0000, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    snap(b + 16, 4'b0001, 1'b0, 2'd0, 1'b1, 1'b1, 1'b1, 1'b0);
    ev(b + 16, 4'b0001, 1'b0, 2'd0);
    ev(b + 20, 4'b0011, 1'b0, 2'd0);
    ev(b + 24, 4'b0111, 1'b0, 2'd0);
    ev(b + 28, 4'b1111, 1'b1, 2'd0);
    wait_to(b + 30);

    // External glitch of two cycles is filtered out
    b = cyc;
    snap(b + 10, 4'b1111, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    ext_rst_req_n = 1'b0;
    wait_to(b + 2);
    ext_rst_req_n = 1'b1;
    wait_to(b + 12);

    // External request held for ten cycles
    b = cyc;
    snap(b + 5, 4'b1111, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    ev(b + 6, 4'b0000, 1'b0, 2'd1);
    ext_rst_req_n = 1'b0;
    wait_to(b + 10);
    ext_rst_req_n = 1'b1;
    snap(b + 28, 4'b0000, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    ev(b + 29, 4'b0001, 1'b0, 2'd1);
    ev(b + 33, 4'b0011, 1'b0, 2'd1);
    ev(b + 37, 4'b0111, 1'b0, 2'd1);
    ev(b + 41, 4'b1111, 1'b1, 2'd1);
    wait_to(b + 44);

    // Software pulse, then a second pulse during the hold restarts it
    b = cyc + 1;
    ev(b, 4'b0000, 1'b0, 2'd2);
    sw_rst_req = 1'b1;
    wait_to(b);
    sw_rst_req = 1'b0;
    wait_to(b + 9);
    sw_rst_req = 1'b1;
    wait_to(b + 10);
    sw_rst_req = 1'b0;
    snap(b + 25, 4'b0000, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    ev(b + 26, 4'b0001, 1'b0, 2'd2);
    ev(b + 30, 4'b0011, 1'b0, 2'd2);
    ev(b + 34, 4'b0111, 1'b0, 2'd2);
    ev(b + 38, 4'b1111, 1'b1, 2'd2);
    wait_to(b + 40);

    // rst_n pulse from RUN, then again just after channel 1 releases
    b = cyc;
    ev(b + 1, 4'b0000, 1'b0, 2'd0);
    rst_n = 1'b0;
    wait_to(b + 1);
    rst_n = 1'b1;
    ev(b + 17, 4'b0001, 1'b0, 2'd0);
    ev(b + 21, 4'b0011, 1'b0, 2'd0);
    wait_to(b + 21);
    ev(b + 22, 4'b0000, 1'b0, 2'd0);
    rst_n = 1'b0;
    wait_to(b + 22);
    rst_n = 1'b1;
    snap(b + 37, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    ev(b + 38, 4'b0001, 1'b0, 2'd0);
    ev(b + 42, 4'b0011, 1'b0, 2'd0);
    ev(b + 46, 4'b0111, 1'b0, 2'd0);
    ev(b + 50, 4'b1111, 1'b1, 2'd0);
    wait_to(b + 52);

    // External request and software pulse on the same edge: ext wins
    b = cyc;
    ext_rst_req_n = 1'b0;
    wait_to(b + 5);
    sw_rst_req = 1'b1;
    ev(b + 6, 4'b0000, 1'b0, 2'd1);
    wait_to(b + 6);
    sw_rst_req = 1'b0;
    wait_to(b + 7);
    ext_rst_req_n = 1'b1;
    ev(b + 26, 4'b0001, 1'b0, 2'd1);
    ev(b + 30, 4'b0011, 1'b0, 2'd1);
    ev(b + 34, 4'b0111, 1'b0, 2'd1);
    ev(b + 38, 4'b1111, 1'b1, 2'd1);
    wait_to(b + 40);

`ifdef RESET_SEQ_WDT_EN
    // Watchdog: no kick for 8 RUN edges fires it; regular kicks keep it quiet
    b = cyc;
    snap(b + 7, 4'b1111, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    ev(b + 8, 4'b0000, 1'b0, 2'd3);
    wdt_kick = 1'b0;
    snap(b + 20, 4'b0000, 1'b0, 2'd3, 1'b0, 1'b0, 1'b0, 1'b1);
    ev(b + 24, 4'b0001, 1'b0, 2'd3);
    ev(b + 28, 4'b0011, 1'b0, 2'd3);
    ev(b + 32, 4'b0111, 1'b0, 2'd3);
    ev(b + 36, 4'b1111, 1'b1, 2'd3);
    snap(b + 70, 4'b1111, 1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 1'b1);
    wait_to(b + 36);
    for (int k = 0; k < 8; k++) begin
      wdt_kick = 1'b1;
      wait_to(cyc + 1);
      wdt_kick = 1'b0;
      wait_to(cyc + 4);
    end
    wdt_kick = 1'b1;
    wait_to(cyc + 2);
`endif

    fin = 1'b1;
  end

  // Hard stop in case the run never reaches the summary
  initial begin
    #200000;
    $display("FAIL timeout cycles=%0d, required summary before 20000 cycles", cyc);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/reset_seq.md
Name: reset_seq

Overview:
Parametrised reset sequencer, successor to the two-flop reset synchroniser, running on one clock.
- Merges three reset sources: system reset, a filtered external reset pin and a software reset pulse.
- Holds all downstream resets asserted for a minimum time, then releases NCH active-low channel resets in fixed order (channel 0 first) with a programmable gap.
- Sits between the top-level reset input and the core/peripheral blocks; reports the cause of the last reset.

Parameters:
NCH, 4, number of channel reset outputs (>=1)
SYNC_STAGES, 2, synchroniser flops on ext_rst_req_n (>=2)
HOLD_CYC, 16, minimum cycles all channels stay asserted after the last request clears (>=1)
GAP_CYC, 4, cycles between successive channel releases (>=1)
FILTER_CYC, 3, consecutive synced-low samples needed to accept an external request (>=1)

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low; highest priority source
ext_rst_req_n  in  1  asynchronous external reset request, active-low
sw_rst_req  in  1  software reset request, single-cycle pulse, active-high
ch_rst_n  out  NCH  channel resets, active-low, registered
done  out  1  1 when all channels are released
rst_cause  out  2  sticky cause of last reset: 0 = rst_n, 1 = ext, 2 = sw, 3 = wdt

Behaviour:
- Reset (rst_n=0 sampled at an edge):
  - ch_rst_n = 0, done = 0, rst_cause = 0, FSM = ASSERT, all counters = 0.
  - Synchroniser flops load 1 (no request).
- External path:
  - ext_rst_req_n passes through SYNC_STAGES flops, then a consecutive-low counter saturating at FILTER_CYC.
  - Counter clears on a synced-high sample.
  - ext_req is active while the counter equals FILTER_CYC.
  - Default latency: ch_rst_n drops after edge SYNC_STAGES+FILTER_CYC+1 counted from the first edge sampling ext low (6 with defaults).
  - Pulses shorter than FILTER_CYC synced cycles cause no reset.
- FSM:
  - ASSERT:
    - ch_rst_n = 0.
    - hold_cnt increments on each edge with no active request; clears on any request.
    - At the HOLD_CYC-th such edge: ch_rst_n[0] <= 1, idx <= 1, go to RELEASE (or RUN if NCH=1).
  - RELEASE:
    - gap_cnt counts GAP_CYC edges, then ch_rst_n[idx] <= 1 and idx increments.
    - When the edge releases ch_rst_n[NCH-1], done <= 1 on the same edge and the FSM goes to RUN.
  - RUN:
    - All channels released; waits for a request.
  - Any request in any state: on that edge ch_rst_n <= 0, done <= 0, FSM = ASSERT, counters cleared.
- Release order: channels release strictly ascending; never more than one bit changes per release edge.
- Request priority:
  - rst_n > ext > wdt > sw.
  - rst_cause takes the highest-priority source active on that edge.
  - rst_cause updates only when a request begins or re-asserts.
- Request semantics:
  - Level requests (ext, rst_n) keep the FSM in ASSERT with hold_cnt = 0 until they clear.
  - sw_rst_req in ASSERT restarts hold_cnt.
  - The first edge after a sw pulse counts as hold edge 1.
- Counter width: $clog2(max(HOLD_CYC, GAP_CYC, FILTER_CYC)+1).

Optional Feature:
RESET_SEQ_WDT_EN
- Defined:
  - Adds parameter WDT_CYC (default 1024), input wdt_kick (1 bit) and output wdt_fired (1 bit, sticky, cleared only by rst_n).
  - In RUN, a wdt counter increments each edge and clears on wdt_kick.
  - On reaching WDT_CYC it issues a one-cycle wdt request: rst_cause = 3, wdt_fired = 1.
  - The wdt counter is held at 0 outside RUN.
- Undefined:
  - No wdt ports, parameter or logic.
  - rst_cause never takes the value 3.

Test Plan:
- Power-up (defaults): rst_n low 5 cycles, first edge with rst_n=1 is edge 1 -> ch_rst_n[0..3] rise after edges 16/20/24/28; done=1 after edge 28; rst_cause=0.
- Ext glitch: ext_rst_req_n low for 2 cycles -> no change. Low for 10 cycles from RUN -> ch_rst_n=4'b0000 after edge 6, rst_cause=1. After ext rises, ch_rst_n[0] rises 18 edges after the first edge sampling it high.
- sw_rst_req pulse sampled at edge E in RUN -> ch_rst_n=0, done=0 after E; ch_rst_n[0] rises after E+16; rst_cause=2. Second pulse at E+10 -> ch_rst_n[0] rises after E+26.
- rst_n low 1 cycle after ch_rst_n[1] released -> all channels 0 next edge, rst_cause=0, full sequence restarts with the power-up timing.
- ext_req becoming active on the same edge as sw_rst_req=1 -> rst_cause=1; NCH=1, GAP_CYC=1 build -> done rises with ch_rst_n[0] after edge 16.
- RESET_SEQ_WDT_EN, WDT_CYC=8: no kick in RUN -> reset after 8 edges, rst_cause=3, wdt_fired=1 held through re-sequence. Kick every 5 cycles -> never fires.
